// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: machine widths, canonical NOP and the {pc, instr} queue entry.
package pipeline_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head is read straight from storage, so it is valid the cycle after a push.
// Push when full and pop when empty are ignored; clear empties the FIFO and wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !clear && (r_count != CW'(DEPTH));
  assign w_pop  = pop && !clear && (r_count != '0);
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue: issues in-order imem reads bounded by free queue slots and presents one entry per cycle to IF-ID.
// Response-to-output latency is one cycle; a redirect flushes the queue and turns in-flight requests into drops.
module instr_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            deq_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW2 = CW + 2;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_pending;
  logic [CW2-1:0]  w_used;
  logic [CW:0]     w_outstanding;
  logic [CW-1:0]   w_drop_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pend_pc;
  fetch_entry_t    w_enq;
  fetch_entry_t    w_head;
  logic            w_issue;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_deq;

  // Credit counts every slot a granted request may eventually occupy, including stale ones.
  assign w_used    = {2'b00, w_count} + {2'b00, w_pending} + {2'b00, r_drop};
  assign imem_req  = !rst && !redirect && (w_used < CW2'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_rsp_drop = imem_rvalid && (r_drop != '0);
  assign w_rsp_take = imem_rvalid && (r_drop == '0) && (w_pending != '0);

  assign out_valid = (w_count != '0);
  assign w_deq     = out_valid && deq_ready;
  assign out_pc    = out_valid ? w_head.pc : '0;
  assign out_instr = out_valid ? w_head.instr : NOP_INSTR;

  assign w_enq    = '{pc: w_pend_pc, instr: imem_rdata};
  assign w_target = redirect_pc & ~64'h3;

  // A response arriving in the redirect cycle retires one of the requests being turned stale.
  assign w_outstanding   = {1'b0, r_drop} + {1'b0, w_pending};
  assign w_drop_redirect = (imem_rvalid && (w_outstanding != '0)) ? CW'(w_outstanding - 1'b1)
                                                                   : CW'(w_outstanding);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_target;
      r_drop     <= w_drop_redirect;
    end else begin
      if (w_issue)    r_fetch_pc <= r_fetch_pc + 64'd4;
      if (w_rsp_drop) r_drop     <= r_drop - 1'b1;
    end
  end

  // The pending count is the occupancy of the PC FIFO.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_issue),
    .push_data (r_fetch_pc),
    .pop       (w_rsp_take),
    .clear     (redirect),
    .head      (w_pend_pc),
    .count     (w_pending)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_rsp_take),
    .push_data (w_enq),
    .pop       (w_deq),
    .clear     (redirect),
    .head      (w_head),
    .count     (w_count)
  );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench: a latency-programmable in-order memory model, a per-cycle vector table and corner-case sequences.
module tb_instr_prefetch_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        deq_ready;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_ready   (deq_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        deq;
    logic        gnt;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  req_t        mem_q[$];
  int          cyc;
  int          lat;
  int          n_gnt;
  int          n_chk;
  int          n_pass;
  logic        s_req;
  logic        s_valid;
  logic [63:0] s_addr;
  logic [63:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {16'hA5C3, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Samples the current cycle at the falling edge, records grants, then advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    if (imem_req && imem_gnt) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      n_gnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    deq_ready   = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_q.delete();
    tick();
    rst   = 1'b0;
    cyc   = 0;
    n_gnt = 0;
    mem_q.delete();
    imem_rvalid = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic found;
    int   stale;
    n_chk = 0;
    n_pass = 0;
    lat = 1;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 64'd4,  1'b0, 64'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 64'd8,  1'b1, 64'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'd12, 1'b1, 64'd4};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 64'd16, 1'b1, 64'd8};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 64'd20, 1'b1, 64'd12};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 64'd24, 1'b1, 64'd12};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 64'd28, 1'b1, 64'd12};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 64'd28, 1'b1, 64'd16};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 64'd32, 1'b1, 64'd20};

    // Reset values while rst is held
    do_reset();
    chk("rst req",   {63'b0, s_req},   64'd0);
    chk("rst valid", {63'b0, s_valid}, 64'd0);
    chk("rst pc",    s_pc,             64'd0);
    chk("rst instr", {32'b0, s_instr}, {32'b0, NOP_INSTR});

    // Streaming with k=1, then a short stall and a grant gap
    for (int i = 0; i < 10; i++) begin
      deq_ready = vecs[i].deq;
      imem_gnt  = vecs[i].gnt;
      tick();
      chk($sformatf("v%0d req", i),   {63'b0, s_req},   {63'b0, vecs[i].exp_req});
      chk($sformatf("v%0d addr", i),  s_addr,           vecs[i].exp_addr);
      chk($sformatf("v%0d valid", i), {63'b0, s_valid}, {63'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d pc", i),    s_pc,             vecs[i].exp_pc);
      chk($sformatf("v%0d instr", i), {32'b0, s_instr},
          {32'b0, vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : NOP_INSTR});
    end

    // Long stall: credit caps grants at DEPTH, head holds, release drains in order
    do_reset();
    lat = 1;
    deq_ready = 1'b0;
    imem_gnt  = 1'b1;
    repeat (10) tick();
    chk("stall grants", 64'(n_gnt), 64'd4);
    chk("stall req",   {63'b0, s_req},   64'd0);
    chk("stall valid", {63'b0, s_valid}, 64'd1);
    chk("stall pc",    s_pc,             64'd0);
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drain%0d valid", i), {63'b0, s_valid}, 64'd1);
      chk($sformatf("drain%0d pc", i),    s_pc,             64'(4 * i));
    end

    // Redirect with two requests in flight (k=3)
    do_reset();
    lat = 3;
    imem_gnt = 1'b1;
    tick();
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    tick();
    chk("redir req", {63'b0, s_req}, 64'd0);
    redirect = 1'b0;
    imem_gnt = 1'b1;
    tick();
    chk("redir next req",  {63'b0, s_req}, 64'd1);
    chk("redir next addr", s_addr,         64'h100);
    found = 1'b0;
    stale = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_valid) begin
        found = 1'b1;
        if (s_pc < 64'h100) stale++;
      end
    end
    chk("redir found",  {63'b0, found}, 64'd1);
    chk("redir pc",     s_pc,           64'h100);
    chk("redir instr",  {32'b0, s_instr}, {32'b0, instr_of(64'h100)});
    chk("redir stale",  64'(stale),     64'd0);

    // Redirect coinciding with a response, pending=2
    do_reset();
    lat = 2;
    imem_gnt = 1'b1;
    tick();
    tick();
    chk("coinc rvalid", {63'b0, imem_rvalid}, 64'd1);
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    found = 1'b0;
    stale = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_valid) begin
        found = 1'b1;
        if (s_pc < 64'h100) stale++;
      end
    end
    chk("coinc found", {63'b0, found}, 64'd1);
    chk("coinc pc",    s_pc,           64'h100);
    chk("coinc stale", 64'(stale),     64'd0);
    tick();
    chk("coinc next valid", {63'b0, s_valid}, 64'd1);
    chk("coinc next pc",    s_pc,             64'h104);

    // Grant withheld: request and address hold
    do_reset();
    lat = 1;
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("nognt%0d req", i),  {63'b0, s_req}, 64'd1);
      chk($sformatf("nognt%0d addr", i), s_addr,         64'd0);
    end
    imem_gnt = 1'b1;
    tick();
    tick();
    chk("gnt resume addr", s_addr, 64'd4);

    // Reset mid-stream with the queue full
    do_reset();
    lat = 1;
    deq_ready = 1'b0;
    imem_gnt  = 1'b1;
    repeat (8) tick();
    chk("full valid", {63'b0, s_valid}, 64'd1);
    chk("full req",   {63'b0, s_req},   64'd0);
    rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    chk("midrst req",   {63'b0, imem_req},  64'd0);
    chk("midrst valid", {63'b0, out_valid}, 64'd0);
    chk("midrst pc",    out_pc,             64'd0);
    chk("midrst instr", {32'b0, out_instr}, {32'b0, NOP_INSTR});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mem_q.delete();
    tick();
    chk("postrst req",  {63'b0, s_req}, 64'd1);
    chk("postrst addr", s_addr,         64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
